mul_div_unit: RTL

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_unit.sv | 119 +++++++++++
 1 files changed

// File: rtl/mul_div_unit.sv
// Multiply/divide unit with HI/LO registers: the result is computed at the start edge,
// then released after a fixed busy period that models the multi-cycle latency.
module mul_div_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = ($clog2(MAX_CYCLES + 1) > 4) ? $clog2(MAX_CYCLES + 1) : 4;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [0:0] {IDLE, RUN} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [31:0]        hi_shadow, lo_shadow;

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic signed [31:0] a_s, quot_s, rem_s;
  logic        [31:0] div_b, quot_u, rem_u;
  logic        [31:0] res_hi, res_lo;

  assign stall_req = (start && (md_op >= OP_MULT) && (md_op <= OP_DIVU)) || busy;

  // Result datapath; a zero divisor is replaced by 1 and its result discarded.
  always_comb begin
    a_s    = signed'(A);
    prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    prod_u = {32'd0, A} * {32'd0, B};
    div_b  = (B == 32'd0) ? 32'd1 : B;
    quot_u = A / div_b;
    rem_u  = A % div_b;
    // Dividing by -1 is a negate; this also covers the 0x80000000 / -1 overflow case.
    if (B == 32'hFFFF_FFFF) begin
      quot_s = 32'sd0 - a_s;
      rem_s  = 32'sd0;
    end else begin
      quot_s = a_s / signed'(div_b);
      rem_s  = a_s % signed'(div_b);
    end
    res_hi = hi_out;
    res_lo = lo_out;
    case (md_op)
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      OP_DIV:   if (B != 32'd0) {res_hi, res_lo} = {rem_s, quot_s};
      OP_DIVU:  if (B != 32'd0) {res_hi, res_lo} = {rem_u, quot_u};
      default: ;
    endcase
  end

  // Control FSM; starts are only honoured in IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      busy      <= 1'b0;
      hi_out    <= 32'd0;
      lo_out    <= 32'd0;
      hi_shadow <= 32'd0;
      lo_shadow <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            case (md_op)
              OP_MULT, OP_MULTU: begin
                hi_shadow <= res_hi;
                lo_shadow <= res_lo;
                cnt       <= CNT_W'(MULT_CYCLES);
                busy      <= 1'b1;
                state     <= RUN;
              end
              OP_DIV, OP_DIVU: begin
                hi_shadow <= res_hi;
                lo_shadow <= res_lo;
                cnt       <= CNT_W'(DIV_CYCLES);
                busy      <= 1'b1;
                state     <= RUN;
              end
              OP_MTHI: hi_out <= A;
              OP_MTLO: lo_out <= A;
              default: ;
            endcase
          end
        end
        RUN: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            hi_out <= hi_shadow;
            lo_out <= lo_shadow;
            busy   <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
